ysyx_22050598_pipe_ctrl: RTL and testbench
==========================================

Name: ysyx_22050598_pipe_ctrl

Overview:
Central hazard and sequencing controller for the five-stage pipeline.
- Generates every stall and flush enable for the IF, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Causes handled: load-use hazards, multi-cycle mul/div, LSU wait, branch/jump redirects and traps.
- Drops the stale fetch that is in flight when a redirect occurs.
- Keeps a performance counter of lost issue cycles.

Parameters:
CNT_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
id_rs1_idx  in  5  source 1 index of instruction in ID
id_rs2_idx  in  5  source 2 index of instruction in ID
id_rs1_ren  in  1  ID reads rs1
id_rs2_ren  in  1  ID reads rs2
ex_rd_idx  in  5  destination index of instruction in EX
ex_is_load  in  1  EX holds a load (ls_req & ~store)
ex_muldiv_start  in  1  EX holds a mul/div/rem op (first cycle in EX)
ex_muldiv_done  in  1  mul/div result valid this cycle
mem_ls_busy  in  1  LSU waiting on memory response
if_fetch_busy  in  1  instruction fetch outstanding, no valid inst this cycle
ex_redirect  in  1  taken branch/jal/jalr resolved in EX
trap_req  in  1  ecall/mret/illegal redirect from EX
if_stall  out  1  hold PC
if_id_stall  out  1  hold IF_ID
if_id_flush  out  1  bubble into IF_ID
id_ex_stall  out  1  hold ID_EX
id_ex_flush  out  1  bubble into ID_EX
ex_mem_stall  out  1  hold EX_MEM
ex_mem_flush  out  1  bubble into EX_MEM
mem_wb_flush  out  1  bubble into MEM_WB
stall_cnt  out  CNT_W  cycles with id_ex_stall or id_ex_flush

Behaviour:
- States: RUN, MD_WAIT, DROP. Reset to RUN; stall_cnt=0.
- While rst=1: all *_stall=0, all *_flush=1.
- Outputs are combinational from state and inputs, with zero latency. Per stage, stall and flush are never both 1.
- Priority, first match wins:
  1. mem_ls_busy: if_stall, if_id_stall, id_ex_stall, ex_mem_stall=1; mem_wb_flush=1. No other flush. State unchanged; a pending redirect/trap is re-seen when EX is released.
  2. MD_WAIT, or RUN with ex_muldiv_start & ~ex_muldiv_done: if_stall, if_id_stall, id_ex_stall=1; ex_mem_flush=1.
  3. trap_req: if_id_flush, id_ex_flush, ex_mem_flush=1.
  4. ex_redirect: if_id_flush, id_ex_flush=1.
  5. Load-use: ex_is_load & ex_rd_idx!=0 & ((id_rs1_ren & rs1==rd) | (id_rs2_ren & rs2==rd)). Drives if_stall, if_id_stall=1 and id_ex_flush=1.
  6. DROP, or if_fetch_busy: if_id_flush=1.
  7. Otherwise all outputs are 0.
- Transitions:
  - RUN->MD_WAIT on rule 2 with ex_muldiv_start & ~ex_muldiv_done.
  - MD_WAIT->RUN in the cycle ex_muldiv_done=1. That cycle still stalls and releases next cycle.
  - RUN->DROP when rule 3 or 4 fires and if_fetch_busy=1.
  - DROP->RUN when if_fetch_busy=0. The instruction returning in that cycle is flushed, giving one more if_id_flush.
  - Redirect/trap during DROP: stay in DROP.
  - Start with done in the same cycle: no state change, no stall.
- mem_ls_busy has priority in every state, but FSM transitions still occur:
  - ex_muldiv_done is honoured even when masked by rule 1.
  - DROP exit is honoured even when masked by rule 1.
- stall_cnt increments by 1 when (id_ex_stall | id_ex_flush) & ~rst. It wraps modulo 2^CNT_W.
- x0 never creates a load-use hazard.

Test Plan:
- Load-use: EX load rd=5, ID rs1=5 ren=1 -> one cycle of if_stall=if_id_stall=id_ex_flush=1; next cycle all 0. Same with rd=0 -> no stall.
- Mul/div: ex_muldiv_start=1, done at cycle +4 -> MD_WAIT. Stalls and ex_mem_flush are held for 5 cycles, then released. stall_cnt +=5.
- Redirect with fetch busy: ex_redirect=1, if_fetch_busy=1 for 3 cycles -> DROP. if_id_flush=1 for 4 cycles; id_ex_flush=1 only in the first cycle.
- LSU busy over trap: mem_ls_busy=1 & trap_req=1 for 2 cycles -> only stalls + mem_wb_flush. When busy drops, trap flushes IF_ID/ID_EX/EX_MEM in that cycle.
- Reset mid-MD_WAIT: assert rst for 1 cycle -> all flushes=1 and stalls=0 during reset. State returns to RUN and stall_cnt=0.
- Counter wrap: CNT_W=4, 17 stall cycles -> stall_cnt=1.

Source files
------------

// File: rtl/ysyx_22050598_pipe_ctrl.sv
// rtl/ysyx_22050598_pipe_ctrl.sv - pipeline hazard, stall/flush and redirect sequencing controller
module ysyx_22050598_pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_idx,
  input  logic [4:0]       id_rs2_idx,
  input  logic             id_rs1_ren,
  input  logic             id_rs2_ren,
  input  logic [4:0]       ex_rd_idx,
  input  logic             ex_is_load,
  input  logic             ex_muldiv_start,
  input  logic             ex_muldiv_done,
  input  logic             mem_ls_busy,
  input  logic             if_fetch_busy,
  input  logic             ex_redirect,
  input  logic             trap_req,
  output logic             if_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MD_WAIT, DROP} state_t;

  state_t state;
  state_t state_nxt;

  logic md_hold;
  logic md_enter;
  logic load_use;
  logic redirect_any;

  assign md_enter     = (state == RUN) && ex_muldiv_start && !ex_muldiv_done;
  assign md_hold      = (state == MD_WAIT) || md_enter;
  assign redirect_any = trap_req || ex_redirect;
  assign load_use     = ex_is_load && (ex_rd_idx != 5'd0) &&
                        ((id_rs1_ren && (id_rs1_idx == ex_rd_idx)) ||
                         (id_rs2_ren && (id_rs2_idx == ex_rd_idx)));

  // Outputs are purely combinational so a hazard is covered in the cycle it appears.
  always_comb begin
    if_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_ls_busy) begin
      if_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (md_hold) begin
      if_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (trap_req) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      if_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if ((state == DROP) || if_fetch_busy) begin
      if_id_flush  = 1'b1;
    end
  end

  // While the LSU holds the pipe only the exits (mul/div done, stale fetch returned) advance.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (!mem_ls_busy) begin
          if (md_enter) state_nxt = MD_WAIT;
          else if (redirect_any && if_fetch_busy) state_nxt = DROP;
        end
      end
      MD_WAIT: begin
        if (ex_muldiv_done) state_nxt = RUN;
      end
      DROP: begin
        if (!if_fetch_busy) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (id_ex_stall || id_ex_flush) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_22050598_pipe_ctrl.sv
// tb/tb_ysyx_22050598_pipe_ctrl.sv - directed self-checking bench for the pipeline controller
module tb_ysyx_22050598_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_idx, id_rs2_idx, ex_rd_idx;
  logic       id_rs1_ren, id_rs2_ren, ex_is_load;
  logic       ex_muldiv_start, ex_muldiv_done, mem_ls_busy, if_fetch_busy;
  logic       ex_redirect, trap_req;
  logic       if_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, ex_mem_flush, mem_wb_flush;
  logic [3:0] stall_cnt;
  logic [7:0] outs;
  logic [3:0] exp_cnt;
  int         n_chk = 0;
  int         n_fail = 0;

  // Packed order: if_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush
  localparam logic [7:0] O_NONE = 8'h00, O_LSU = 8'hD5, O_MD = 8'hD2, O_TRAP = 8'h2A;
  localparam logic [7:0] O_REDIR = 8'h28, O_LU = 8'hC8, O_FETCH = 8'h20, O_RST = 8'h2B;

  ysyx_22050598_pipe_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .ex_rd_idx(ex_rd_idx), .ex_is_load(ex_is_load),
    .ex_muldiv_start(ex_muldiv_start), .ex_muldiv_done(ex_muldiv_done),
    .mem_ls_busy(mem_ls_busy), .if_fetch_busy(if_fetch_busy),
    .ex_redirect(ex_redirect), .trap_req(trap_req),
    .if_stall(if_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {if_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                 ex_mem_stall, ex_mem_flush, mem_wb_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the counter model past the edge.
  task automatic step(input string tag, input logic [7:0] e);
    @(negedge clk);
    chk(tag, {24'd0, outs}, {24'd0, e});
    chk({tag, "_cnt"}, {28'd0, stall_cnt}, {28'd0, exp_cnt});
    @(posedge clk);
    #1;
    if (rst) exp_cnt = 4'd0;
    else if (e[4] || e[3]) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic clear_inputs();
    id_rs1_idx = 5'd0; id_rs2_idx = 5'd0; ex_rd_idx = 5'd0;
    id_rs1_ren = 1'b0; id_rs2_ren = 1'b0; ex_is_load = 1'b0;
    ex_muldiv_start = 1'b0; ex_muldiv_done = 1'b0; mem_ls_busy = 1'b0;
    if_fetch_busy = 1'b0; ex_redirect = 1'b0; trap_req = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    exp_cnt = 4'd0;
    @(posedge clk);
    #1;
    step("reset", O_RST);
    rst = 1'b0;
    step("idle", O_NONE);

    ex_is_load = 1'b1; ex_rd_idx = 5'd5; id_rs1_idx = 5'd5; id_rs1_ren = 1'b1;
    step("lu_rs1", O_LU);
    clear_inputs();
    step("lu_rs1_after", O_NONE);

    ex_is_load = 1'b1; ex_rd_idx = 5'd7; id_rs2_idx = 5'd7; id_rs2_ren = 1'b1;
    step("lu_rs2", O_LU);
    id_rs2_ren = 1'b0;
    step("lu_rs2_noren", O_NONE);
    clear_inputs();
    ex_is_load = 1'b1; id_rs1_ren = 1'b1;
    step("lu_x0", O_NONE);
    ex_rd_idx = 5'd3; id_rs1_idx = 5'd3; if_fetch_busy = 1'b1;
    step("lu_over_fetch", O_LU);
    ex_redirect = 1'b1; if_fetch_busy = 1'b0;
    step("redir_over_lu", O_REDIR);
    clear_inputs();

    ex_muldiv_start = 1'b1;
    for (int i = 0; i < 4; i++) step("md_wait", O_MD);
    ex_muldiv_done = 1'b1;
    step("md_done", O_MD);
    clear_inputs();
    step("md_release", O_NONE);
    ex_muldiv_start = 1'b1; ex_muldiv_done = 1'b1;
    step("md_same_cycle", O_NONE);
    clear_inputs();
    step("md_same_after", O_NONE);

    ex_redirect = 1'b1; if_fetch_busy = 1'b1;
    step("redir_busy", O_REDIR);
    ex_redirect = 1'b0;
    step("drop1", O_FETCH);
    step("drop2", O_FETCH);
    if_fetch_busy = 1'b0;
    step("drop_exit", O_FETCH);
    step("drop_done", O_NONE);
    ex_redirect = 1'b1;
    step("redir_idle", O_REDIR);
    clear_inputs();
    step("redir_idle_after", O_NONE);

    mem_ls_busy = 1'b1; trap_req = 1'b1;
    step("lsu_trap1", O_LSU);
    step("lsu_trap2", O_LSU);
    mem_ls_busy = 1'b0;
    step("trap_released", O_TRAP);
    clear_inputs();
    step("trap_after", O_NONE);

    trap_req = 1'b1; if_fetch_busy = 1'b1;
    step("trap_busy", O_TRAP);
    trap_req = 1'b0; if_fetch_busy = 1'b0; mem_ls_busy = 1'b1;
    step("drop_exit_masked", O_LSU);
    mem_ls_busy = 1'b0;
    step("drop_exit_masked_after", O_NONE);

    ex_muldiv_start = 1'b1;
    step("md_enter", O_MD);
    ex_muldiv_start = 1'b0; ex_muldiv_done = 1'b1; mem_ls_busy = 1'b1;
    step("md_done_masked", O_LSU);
    clear_inputs();
    step("md_done_masked_after", O_NONE);

    ex_muldiv_start = 1'b1;
    step("md_before_rst", O_MD);
    ex_muldiv_start = 1'b0; rst = 1'b1;
    step("rst_mid_md", O_RST);
    rst = 1'b0;
    step("after_rst", O_NONE);
    if_fetch_busy = 1'b1;
    step("fetch_busy", O_FETCH);
    clear_inputs();

    ex_is_load = 1'b1; ex_rd_idx = 5'd9; id_rs2_idx = 5'd9; id_rs2_ren = 1'b1;
    for (int i = 0; i < 17; i++) step("wrap_lu", O_LU);
    clear_inputs();
    step("wrap_after", O_NONE);
    chk("wrap_value", {28'd0, stall_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
